// File: rtl/kem_keccak_arbiter.sv
// kem_keccak_arbiter: round-robin sequencer sharing one Keccak-f[1600] core
// between ML-KEM requesters. Grants one requester at a time, pulses the core
// start, waits for a Ready rising edge (or watchdog expiry), and returns the
// captured output state together with a one-cycle done pulse.
module kem_keccak_arbiter #(
    parameter int N_REQ  = 3,
    parameter int W_ST   = 1600,
    parameter int TO_CYC = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [N_REQ-1:0]      req_i,
    input  logic [N_REQ*W_ST-1:0] din_i,
    output logic [N_REQ-1:0]      gnt_o,
    output logic [N_REQ-1:0]      done_o,
    output logic                  err_o,
    output logic [W_ST-1:0]       dout_o,
    output logic                  busy_o,
    output logic                  core_start_o,
    output logic [W_ST-1:0]       core_din_o,
    input  logic                  core_rdy_i,
    input  logic [W_ST-1:0]       core_dout_i
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e           state_q;
    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    sel_q;
    logic [15:0]      wdog_q;
    logic             rdy_prev_q;
    logic             err_q;
    logic             busy_q;
    logic             start_q;
    logic [N_REQ-1:0] gnt_q;
    logic [N_REQ-1:0] done_q;
    logic [W_ST-1:0]  dout_q;

    logic             pick_vld;
    logic [PW-1:0]    pick_idx;
    logic [PW:0]      idx_w;
    logic             rdy_edge;
    logic [W_ST-1:0]  din_arr [N_REQ];

    // Per-requester view of the flat input-state bus
    for (genvar g = 0; g < N_REQ; g++) begin : g_din
        assign din_arr[g] = din_i[g*W_ST +: W_ST];
    end

    // First requesting index at or after the pointer, wrapping around
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        idx_w    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_w = {1'b0, ptr_q} + (PW+1)'(k);
            if (idx_w >= (PW+1)'(N_REQ)) begin
                idx_w = idx_w - (PW+1)'(N_REQ);
            end
            if (!pick_vld && req_i[idx_w[PW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = idx_w[PW-1:0];
            end
        end
    end

    // A Ready level that was already high the cycle before is not completion
    assign rdy_edge = core_rdy_i & ~rdy_prev_q;

    // Sequencer FSM with registered grant/start/done/err/dout outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            sel_q      <= '0;
            wdog_q     <= '0;
            rdy_prev_q <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            start_q    <= 1'b0;
            gnt_q      <= '0;
            done_q     <= '0;
            dout_q     <= '0;
        end else begin
            rdy_prev_q <= core_rdy_i;
            start_q    <= 1'b0;
            done_q     <= '0;
            err_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pick_vld) begin
                        sel_q   <= pick_idx;
                        gnt_q   <= N_REQ'(1) << pick_idx;
                        busy_q  <= 1'b1;
                        start_q <= 1'b1;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    wdog_q  <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (rdy_edge) begin
                        dout_q  <= core_dout_i;
                        done_q  <= gnt_q;
                        state_q <= S_DONE;
                    end else if (wdog_q == 16'(TO_CYC)) begin
                        // hung core: report done with error, keep old dout
                        done_q  <= gnt_q;
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        wdog_q <= wdog_q + 16'd1;
                    end
                end
                S_DONE: begin
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    ptr_q   <= (sel_q == PW'(N_REQ-1)) ? '0 : sel_q + PW'(1);
                    state_q <= S_IDLE;
                end
                default: begin
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt_o        = gnt_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign dout_o       = dout_q;
    assign busy_o       = busy_q;
    assign core_start_o = start_q;
    assign core_din_o   = busy_q ? din_arr[sel_q] : '0;

endmodule

// File: tb/tb_kem_keccak_arbiter.sv
// Bench for kem_keccak_arbiter: a cycle-level rule model (round-robin pick,
// edge-or-timeout completion) checked every cycle, a behavioural Keccak core
// with programmable latency, directed scenarios and a randomized phase.
module tb_kem_keccak_arbiter;
    localparam int N  = 3;
    localparam int W  = 1600;
    localparam int TO = 255;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_i;
    logic [N*W-1:0] din_i;
    logic [N-1:0]   gnt_o, done_o;
    logic           err_o, busy_o, core_start_o;
    logic [W-1:0]   dout_o, core_din_o;
    logic           core_rdy_i;
    logic [W-1:0]   core_dout_i;

    kem_keccak_arbiter #(.N_REQ(N), .W_ST(W), .TO_CYC(TO)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req_i), .din_i(din_i),
        .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .dout_o(dout_o),
        .busy_o(busy_o), .core_start_o(core_start_o), .core_din_o(core_din_o),
        .core_rdy_i(core_rdy_i), .core_dout_i(core_dout_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rnd_state();
        logic [W-1:0] v;
        for (int i = 0; i < W/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int pick(input int ptr, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) if (r[(ptr+k)%N]) return (ptr+k)%N;
        return -1;
    endfunction

    // ---------------- behavioural core ----------------
    int           core_lat = 3;   // -1 never ready, -2 random per start
    bit           sticky = 1'b0;  // keep Ready high after start, drop later
    bit           rdy_preset = 1'b0;
    logic [W-1:0] last_cap = '0;

    initial begin
        int  cnt, lat;
        bit  s;
        cnt = 0;
        core_rdy_i = 1'b0;
        core_dout_i = '0;
        forever begin
            @(negedge clk);
            s = core_start_o;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                core_rdy_i = rdy_preset;
                cnt = 0;
            end else if (s) begin
                if (core_lat == -2) lat = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(1, 20));
                else lat = core_lat;
                if (!sticky) core_rdy_i = 1'b0;
                cnt = lat;
            end else if (cnt > 0) begin
                cnt--;
                if (sticky && cnt == 5) core_rdy_i = 1'b0;
                if (cnt == 0) begin
                    core_dout_i = rnd_state();
                    last_cap = core_dout_i;
                    core_rdy_i = 1'b1;
                end
            end
        end
    end

    // ---------------- rule model + per-cycle compare ----------------
    initial begin
        logic [N-1:0] m_gnt, m_done, m_dnext, e_gnt, e_done, p_req;
        logic [W-1:0] m_dout, m_dout_nxt, e_din;
        bit           m_enext, e_err, m_wait, e_start, p_rdy;
        int           m_ptr, m_idx, m_wcnt, pk;
        m_gnt = '0; m_done = '0; m_dnext = '0; p_req = '0;
        m_dout = '0; m_dout_nxt = '0; m_enext = 0; m_wait = 0; p_rdy = 0;
        m_ptr = 0; m_idx = 0; m_wcnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk(gnt_o === '0, "rst gnt", 64'(gnt_o), 0);
                chk(done_o === '0, "rst done", 64'(done_o), 0);
                chk(err_o === 1'b0, "rst err", 64'(err_o), 0);
                chk(busy_o === 1'b0, "rst busy", 64'(busy_o), 0);
                chk(core_start_o === 1'b0, "rst start", 64'(core_start_o), 0);
                chk(dout_o === '0, "rst dout", dout_o[63:0], 0);
                m_gnt = '0; m_done = '0; m_dnext = '0; m_enext = 0; m_wait = 0;
                m_ptr = 0; m_dout = '0; m_dout_nxt = '0; p_req = '0;
            end else begin
                m_dout = m_dout_nxt;
                e_gnt = '0;
                if (m_gnt == '0) begin
                    pk = pick(m_ptr, p_req);
                    if (pk >= 0) e_gnt[pk] = 1'b1;
                end else if (m_done == '0) begin
                    e_gnt = m_gnt;
                end
                e_start = (m_gnt == '0) && (e_gnt != '0);
                if (e_start) m_idx = pk;
                e_done = m_dnext;
                e_err  = m_enext;
                e_din  = (e_gnt != '0) ? din_i[m_idx*W +: W] : '0;
                chk(gnt_o === e_gnt, "gnt", 64'(gnt_o), 64'(e_gnt));
                chk(core_start_o === e_start, "core_start", 64'(core_start_o), 64'(e_start));
                chk(busy_o === (e_gnt != '0), "busy", 64'(busy_o), 64'(e_gnt != '0));
                chk(done_o === e_done, "done", 64'(done_o), 64'(e_done));
                chk(err_o === e_err, "err", 64'(err_o), 64'(e_err));
                chk(dout_o === m_dout, "dout", dout_o[63:0], m_dout[63:0]);
                chk(core_din_o === e_din, "core_din", core_din_o[63:0], e_din[63:0]);
                m_dnext = '0;
                m_enext = 0;
                if (m_wait) begin
                    if (core_rdy_i && !p_rdy) begin
                        m_dnext = e_gnt; m_dout_nxt = core_dout_i; m_wait = 0;
                    end else if (m_wcnt == TO) begin
                        m_dnext = e_gnt; m_enext = 1; m_wait = 0;
                    end else begin
                        m_wcnt++;
                    end
                end
                if (e_start) begin m_wait = 1; m_wcnt = 0; end
                if (e_done != '0) m_ptr = (m_idx + 1) % N;
                m_gnt  = e_gnt;
                m_done = e_done;
                p_req  = req_i;
            end
            p_rdy = core_rdy_i;
        end
    end

    // ---------------- stimulus helpers ----------------
    int t_start = 0;
    int t_done  = 0;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_din(input int i);
        din_i[i*W +: W] = rnd_state();
    endtask

    task automatic wait_start(input int maxc, input string nm);
        int n = 0;
        do begin @(negedge clk); n++; end while (core_start_o !== 1'b1 && n < maxc);
        chk(core_start_o === 1'b1, nm, 64'(core_start_o), 1);
        t_start = cyc;
    endtask

    task automatic wait_done(input int maxc, input string nm);
        int n = 0;
        do begin @(negedge clk); n++; end while (done_o === '0 && n < maxc);
        chk(done_o !== '0, nm, 64'(done_o), 1);
        t_done = cyc;
    endtask

    logic [N-1:0] glog [4];
    logic [N-1:0] ord  [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

    initial begin
        #900000;
        $display("FAIL global timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [N-1:0] d;
        int n;
        rst_n = 1'b0; req_i = '0; din_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk(gnt_o == '0 && !busy_o && !core_start_o, "reset idle", 64'({gnt_o, busy_o, core_start_o}), 0);
        chk(dout_o == '0, "reset dout", dout_o[63:0], 0);
        rst_n = 1'b1;
        step(2);

        // all three requesting from pointer 0
        core_lat = 3;
        for (int i = 0; i < N; i++) set_din(i);
        req_i = 3'b111;
        for (int k = 0; k < 4; k++) begin
            wait_start(20, "t2 start timeout");
            glog[k] = gnt_o;
            wait_done(60, "t2 done timeout");
            chk(done_o == glog[k], "t2 done vs grant", 64'(done_o), 64'(glog[k]));
        end
        for (int k = 0; k < 4; k++) chk(glog[k] == ord[k], "t2 grant order", 64'(glog[k]), 64'(ord[k]));

        // requester 1 drops mid-operation; completion still reported
        wait_start(20, "t4 start timeout");
        chk(gnt_o == 3'b010, "t4 grant", 64'(gnt_o), 64'(3'b010));
        step(3);
        req_i[1] = 1'b0;
        wait_done(60, "t4 done timeout");
        chk(done_o == 3'b010, "t4 done", 64'(done_o), 64'(3'b010));
        wait_start(20, "t4 next start timeout");
        chk(gnt_o == 3'b100, "t4 next grant", 64'(gnt_o), 64'(3'b100));
        wait_done(60, "t4 next done timeout");
        step(1); req_i = '0; step(1);

        // single request, Ready after 24 core cycles
        core_lat = 24;
        set_din(0);
        req_i = 3'b001;
        wait_start(10, "t1 start timeout");
        chk(gnt_o == 3'b001, "t1 grant", 64'(gnt_o), 1);
        wait_done(100, "t1 done timeout");
        chk(done_o == 3'b001, "t1 done", 64'(done_o), 1);
        chk(err_o == 1'b0, "t1 err", 64'(err_o), 0);
        chk(t_done - t_start == 26, "t1 latency", 64'(t_done - t_start), 26);
        chk(dout_o == last_cap, "t1 dout", dout_o[63:0], last_cap[63:0]);
        step(1); req_i = '0; step(1);

        // hung core: watchdog expiry
        core_lat = -1;
        req_i = 3'b001;
        wait_start(10, "t3 start timeout");
        wait_done(400, "t3 done timeout");
        chk(done_o == 3'b001, "t3 done", 64'(done_o), 1);
        chk(err_o == 1'b1, "t3 err", 64'(err_o), 1);
        chk(t_done - t_start == 257, "t3 latency", 64'(t_done - t_start), 257);
        chk(dout_o == last_cap, "t3 dout kept", dout_o[63:0], last_cap[63:0]);
        step(1); req_i = '0; step(1);

        // Ready high from reset: only a fresh rising edge completes
        rdy_preset = 1'b1;
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        rdy_preset = 1'b0;
        sticky = 1'b1; core_lat = 20;
        req_i = 3'b001;
        wait_start(10, "t6 start timeout");
        wait_done(60, "t6 done timeout");
        chk(t_done - t_start == 22, "t6 latency", 64'(t_done - t_start), 22);
        chk(done_o == 3'b001 && !err_o, "t6 done", 64'({done_o, err_o}), 64'({3'b001, 1'b0}));
        chk(dout_o == last_cap, "t6 dout", dout_o[63:0], last_cap[63:0]);
        step(1); req_i = '0; sticky = 1'b0; step(1);

        // reset in the middle of WAIT_RDY
        core_lat = -1;
        req_i = 3'b010;
        wait_start(10, "t5 start timeout");
        chk(gnt_o == 3'b010, "t5 grant", 64'(gnt_o), 64'(3'b010));
        step(10);
        #2 rst_n = 1'b0;
        #1;
        chk(gnt_o == '0 && done_o == '0 && !err_o, "t5 async gnt/done/err", 64'({gnt_o, done_o, err_o}), 0);
        chk(!busy_o && !core_start_o, "t5 async busy/start", 64'({busy_o, core_start_o}), 0);
        chk(dout_o == '0, "t5 async dout", dout_o[63:0], 0);
        chk(core_din_o == '0, "t5 async core_din", core_din_o[63:0], 0);
        req_i = 3'b101;
        core_lat = 5;
        step(2);
        rst_n = 1'b1;
        wait_start(10, "t5 restart timeout");
        chk(gnt_o == 3'b001, "t5 pointer reset", 64'(gnt_o), 1);
        wait_done(50, "t5 done timeout");
        step(1); req_i = '0; step(1);

        // randomized traffic
        core_lat = -2;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            d = done_o;
            step(1);
            for (int i = 0; i < N; i++) begin
                if (d[i]) req_i[i] = 1'b0;
                else if (!req_i[i] && $urandom_range(0, 3) == 0) begin
                    set_din(i);
                    req_i[i] = 1'b1;
                end
            end
        end
        n = 0;
        while ((req_i != '0 || busy_o) && n < 3000) begin
            @(negedge clk);
            d = done_o;
            step(1);
            for (int i = 0; i < N; i++) if (d[i]) req_i[i] = 1'b0;
            n++;
        end
        chk(req_i == '0 && !busy_o, "random drain", 64'({req_i, busy_o}), 0);

        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
